stream_dmux: RTL

- Parametrised successor to the 1-to-8 combinational demultiplexer.
- Routes a DATA_W-bit stream from one source to one of N_CH sinks, using valid/ready handshakes on every port.
- Each channel has a one-entry output register, so a stalled sink never corrupts or blocks traffic to other sinks.
- Adds a broadcast mode (one beat to all channels) and a sticky error flag for out-of-range selects. Sits between a single producer and per-channel consumers in the datapath.

---
 rtl/stream_dmux.sv | 103 ++++++++++
 1 files changed

// File: rtl/stream_dmux.sv
// Valid/ready stream demultiplexer: one producer fanned out to N_CH sinks,
// each with a one-entry output register, plus broadcast and an out-of-range error flag.
module stream_dmux #(
    parameter int DATA_W = 8,
    parameter int N_CH   = 8,
    parameter int SEL_W  = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DATA_W-1:0]      in_data,
    input  logic [SEL_W-1:0]       in_sel,
    input  logic                   in_bcast,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [N_CH*DATA_W-1:0] out_data,
    output logic [N_CH-1:0]        out_valid,
    input  logic [N_CH-1:0]        out_ready,
    output logic                   err_sel,
    input  logic                   clr_err
);

    logic [N_CH-1:0]        slot_free;
    logic [N_CH-1:0]        sel_onehot;
    logic [N_CH-1:0]        target;
    logic                   sel_in_range;
    logic                   accept;

    logic [N_CH-1:0]        valid_d, valid_q;
    logic [N_CH*DATA_W-1:0] data_d, data_q;
    logic                   err_d, err_q;

    assign slot_free = ~valid_q | out_ready;

    // A select beyond N_CH matches no channel, so an empty one-hot means out of range.
    always_comb begin
        sel_onehot = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (in_sel == SEL_W'(i)) begin
                sel_onehot[i] = 1'b1;
            end
        end
    end

    assign sel_in_range = |sel_onehot;

    always_comb begin
        in_ready = 1'b1;
        if (in_bcast) begin
            in_ready = &slot_free;
        end else if (sel_in_range) begin
            in_ready = |(sel_onehot & slot_free);
        end
    end

    assign accept = in_valid & in_ready;

    always_comb begin
        target = '0;
        if (accept) begin
            target = in_bcast ? {N_CH{1'b1}} : sel_onehot;
        end
    end

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        for (int i = 0; i < N_CH; i++) begin
            if (target[i]) begin
                valid_d[i]                  = 1'b1;
                data_d[i*DATA_W +: DATA_W]  = in_data;
            end else if (out_ready[i]) begin
                valid_d[i] = 1'b0;
            end
        end
    end

    // A new error wins over a simultaneous clear.
    always_comb begin
        err_d = err_q;
        if (accept && !in_bcast && !sel_in_range) begin
            err_d = 1'b1;
        end else if (clr_err) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign err_sel   = err_q;

endmodule
